// File: rtl/alu_risc_seq.sv
// alu_risc_seq: registered RISC ALU with flags, start/busy/done handshake and shift-add multiplier
module alu_risc_seq #(
    parameter int data_size = 8,
    parameter int op_size   = 4,
    parameter int cnt_size  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [op_size-1:0]   sel,
    input  logic [data_size-1:0] data_1,
    input  logic [data_size-1:0] data_2,
    output logic                 busy,
    output logic                 done,
    output logic [data_size-1:0] alu_out,
    output logic [data_size-1:0] alu_out_hi,
    output logic                 alu_zero_flag,
    output logic                 alu_carry_flag,
    output logic                 alu_neg_flag,
    output logic                 alu_ovf_flag
);
    localparam int M = data_size - 1;
    localparam logic [op_size-1:0] OP_ADD = op_size'(0);
    localparam logic [op_size-1:0] OP_SUB = op_size'(1);
    localparam logic [op_size-1:0] OP_AND = op_size'(2);
    localparam logic [op_size-1:0] OP_OR  = op_size'(3);
    localparam logic [op_size-1:0] OP_NOT = op_size'(4);
    localparam logic [op_size-1:0] OP_XOR = op_size'(5);
    localparam logic [op_size-1:0] OP_SHL = op_size'(6);
    localparam logic [op_size-1:0] OP_SHR = op_size'(7);
    localparam logic [op_size-1:0] OP_MUL = op_size'(8);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                     state_q, state_d;
    logic [2*data_size-1:0]     acc_q, acc_d;
    logic [data_size-1:0]       mcand_q, mcand_d;
    logic [cnt_size-1:0]        cnt_q, cnt_d;
    logic [data_size-1:0]       out_q, out_d, hi_q, hi_d;
    logic                       zero_q, zero_d, carry_q, carry_d, neg_q, neg_d, ovf_q, ovf_d;
    logic                       busy_q, busy_d, done_q, done_d;

    logic [data_size:0]         sum, dif, psum;
    logic [data_size-1:0]       res;
    logic                       res_c, res_v;
    logic [2*data_size-1:0]     acc_nx;

    // Single-cycle result and flags straight from the live inputs
    always_comb begin
        sum   = {1'b0, data_1} + {1'b0, data_2};
        dif   = {1'b0, data_2} - {1'b0, data_1};
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (sel)
            OP_ADD: begin
                res   = sum[M:0];
                res_c = sum[data_size];
                res_v = (data_1[M] == data_2[M]) && (sum[M] != data_1[M]);
            end
            OP_SUB: begin
                res   = dif[M:0];
                res_c = dif[data_size];
                res_v = (data_2[M] != data_1[M]) && (dif[M] != data_2[M]);
            end
            OP_AND: res = data_1 & data_2;
            OP_OR:  res = data_1 | data_2;
            OP_NOT: res = ~data_2;
            OP_XOR: res = data_1 ^ data_2;
            OP_SHL: begin
                res   = {data_2[M-1:0], 1'b0};
                res_c = data_2[M];
            end
            OP_SHR: begin
                res   = {1'b0, data_2[M:1]};
                res_c = data_2[0];
            end
            default: ;
        endcase
    end

    // One shift-add step: add multiplicand into the upper half, then shift {carry, acc} right
    always_comb begin
        psum   = {1'b0, acc_q[2*data_size-1:data_size]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_nx = {psum, acc_q[M:1]};
    end

    // Next state; a MUL passes through DONE so its done pulse lands back in IDLE,
    // where a back-to-back start is accepted while DONE itself ignores start
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (sel == OP_MUL) begin
                    mcand_d = data_1;
                    acc_d   = {{data_size{1'b0}}, data_2};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end else begin
                    out_d   = res;
                    hi_d    = '0;
                    zero_d  = res == '0;
                    carry_d = res_c;
                    neg_d   = res[M];
                    ovf_d   = res_v;
                    done_d  = 1'b1;
                end
            end
            MUL: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + cnt_size'(1);
                if (cnt_q == cnt_size'(data_size - 1)) begin
                    out_d   = acc_nx[M:0];
                    hi_d    = acc_nx[2*data_size-1:data_size];
                    zero_d  = acc_nx == '0;
                    carry_d = 1'b0;
                    neg_d   = acc_nx[2*data_size-1];
                    ovf_d   = |acc_nx[2*data_size-1:data_size];
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything except the zero flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign alu_out        = out_q;
    assign alu_out_hi     = hi_q;
    assign alu_zero_flag  = zero_q;
    assign alu_carry_flag = carry_q;
    assign alu_neg_flag   = neg_q;
    assign alu_ovf_flag   = ovf_q;
endmodule

// File: doc/alu_risc_seq.md
Name: alu_risc_seq

Overview:
- Parametrised, registered successor to the single-cycle RISC ALU.
- Keeps the existing opcode encodings and operand order, and adds XOR, single-bit shifts, and an iterative shift-add multiplier.
- Adds carry, negative and overflow flags, plus a start/busy/done handshake.
- Sits between the register file and the writeback path of the RISC controller; the controller issues one operation at a time.

Parameters:
- data_size, 8, operand and result width (>=4).
- op_size, 4, opcode width.
- cnt_size, 4, multiplier iteration counter width; must satisfy 2**cnt_size > data_size.

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only in IDLE
- sel  input  op_size  opcode, sampled with start
- data_1  input  data_size  operand 1, sampled with start
- data_2  input  data_size  operand 2, sampled with start
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse when the result and flags have just updated
- alu_out  output  data_size  result (low half for MUL)
- alu_out_hi  output  data_size  MUL high half; 0 for all other ops
- alu_zero_flag  output  1  result == 0 (MUL: {hi,lo} == 0)
- alu_carry_flag  output  1  carry/borrow/shift-out
- alu_neg_flag  output  1  MSB of alu_out (MUL: MSB of alu_out_hi)
- alu_ovf_flag  output  1  signed overflow (MUL: hi != 0)

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE.
  - alu_out, alu_out_hi, busy, done, carry, neg, ovf all go to 0.
  - alu_zero_flag goes to 1.
  - Any multiply in progress is aborted with no done pulse.
- Opcodes (unlisted values produce result 0, carry/ovf 0, zero 1):
  - 0 ADD: data_1+data_2; carry = bit data_size of the sum; ovf = operands same sign and result sign differs.
  - 1 SUB: data_2-data_1; carry = borrow (data_2 < data_1, unsigned); ovf = signed overflow of data_2-data_1.
  - 2 AND, 3 OR, 5 XOR: bitwise; carry/ovf 0.
  - 4 NOT: ~data_2; carry/ovf 0.
  - 6 SHL: data_2<<1; carry = data_2[MSB]; ovf 0.
  - 7 SHR: logical data_2>>1; carry = data_2[0]; ovf 0.
  - 8 MUL: unsigned data_1*data_2, 2*data_size-bit product split into hi and lo; carry 0.
- FSM states:
  - IDLE:
    - start=1 with a single-cycle op: result and flags are registered at that same edge; done=1 for the following cycle; stay in IDLE.
    - start=1 with MUL: latch operands, clear accumulator, set counter to 0, busy=1, go to MUL.
  - MUL, one iteration per clock:
    - If multiplier LSB=1, add multiplicand into the upper accumulator half.
    - Shift the {carry, accumulator} right by one; increment the counter.
    - After data_size iterations, write the product to alu_out_hi/alu_out with flags, busy=0, go to DONE.
  - DONE: done=1 for this one cycle; return to IDLE.
- Latency:
  - Single-cycle ops: result visible 1 clock after the start edge.
  - MUL: result at start edge + data_size; done asserted in the following cycle; busy high for exactly data_size cycles.
- Boundary conditions:
  - start while busy or in DONE is ignored; the in-flight operation is not disturbed.
  - start in the same cycle that done is high is accepted (back-to-back issue).
  - Outputs and flags hold their last value until the next accepted operation completes.
  - done never asserts without an accepted start.
  - Operand or sel changes while busy have no effect; operands are latched at start.
- Arithmetic: all internal adders are data_size+1 bits wide; no X propagation from unused opcodes.

Test Plan:
- ADD data_1=200, data_2=100 -> alu_out=44, carry=1, zero=0, ovf=0, done 1 cycle after start.
- SUB data_1=6, data_2=5 -> alu_out=0xFF, carry=1, neg=1; then SUB 5,5 -> alu_out=0, zero=1, carry=0.
- ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1; SHL data_2=0x81 -> 0x02, carry=1; SHR data_2=0x81 -> 0x40, carry=1; sel=15 -> 0, zero=1.
- MUL 0xFF*0xFF -> busy high exactly 8 cycles, hi=0xFE, lo=0x01, ovf=1; a start pulsed mid-multiply with ADD is ignored; MUL 0x10*0x00 -> zero=1, ovf=0.
- Back-to-back: MUL 3*4 then ADD 1+1 issued in the done cycle -> lo=12, then alu_out=2, hi=0, each with its own done pulse.
- rst low at cycle 4 of MUL 0xFF*0xFF -> immediately busy=0, all outputs 0, zero=1, no done; after release, a new MUL 2*3 completes with lo=6.
